div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// Takes 32 cycles in ON, or 2 cycles for a divide-by-zero, and shows the
// result for one cycle in END. stallreq_for_ex holds the pipeline in EX
// until END.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             stallreq_for_ex,
   output logic             result_valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             dvd_neg;   // latched dividend sign (signed op only)
   logic             dvs_neg;   // latched divisor sign (signed op only)
   logic [WIDTH-1:0] dvs_mag;   // latched divisor magnitude
   // {partial remainder (WIDTH+1), dividend/quotient bits (WIDTH)}
   logic [2*WIDTH:0] work;

   logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
   logic             dvd_neg_in, dvs_neg_in;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [2*WIDTH:0] work_nxt;
   logic [WIDTH-1:0] q_mag, r_mag, q_fin, r_fin;

   // Operand magnitudes at the point of latching
   always_comb begin
      dvd_neg_in = signed_div & dividend[WIDTH-1];
      dvs_neg_in = signed_div & divisor[WIDTH-1];
      dvd_mag_in = dvd_neg_in ? (~dividend + 1'b1) : dividend;
      dvs_mag_in = dvs_neg_in ? (~divisor + 1'b1) : divisor;
   end

   // One restoring step: shift left, subtract divisor when it fits.
   // trial is the shifted upper window; the remainder stays below the
   // divisor, so the difference always fits back in WIDTH+1 bits.
   always_comb begin
      trial    = work[2*WIDTH:WIDTH-1];
      fits     = trial >= {2'b00, dvs_mag};
      diff     = trial[WIDTH:0] - {1'b0, dvs_mag};
      work_nxt = fits ? {diff, work[WIDTH-2:0], 1'b1}
                      : {work[2*WIDTH-1:0], 1'b0};
      q_mag    = work_nxt[WIDTH-1:0];
      r_mag    = work_nxt[2*WIDTH-1:WIDTH];
      // negating zero gives zero, so a zero remainder stays zero
      q_fin    = (dvd_neg ^ dvs_neg) ? (~q_mag + 1'b1) : q_mag;
      r_fin    = dvd_neg ? (~r_mag + 1'b1) : r_mag;
   end

   // Stall EX while a divide is requested and its result is not out yet
   always_comb begin
      stallreq_for_ex = start && (state != S_END);
   end

   // Control FSM, datapath registers and registered results
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= S_IDLE;
         cnt          <= '0;
         dvd_neg      <= 1'b0;
         dvs_neg      <= 1'b0;
         dvs_mag      <= '0;
         work         <= '0;
         quotient     <= '0;
         remainder    <= '0;
         result_valid <= 1'b0;
      end else if (flush) begin
         state        <= S_IDLE;
         cnt          <= '0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               result_valid <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     state <= S_DIVZERO;
                  end else begin
                     dvd_neg <= dvd_neg_in;
                     dvs_neg <= dvs_neg_in;
                     dvs_mag <= dvs_mag_in;
                     work    <= {{(WIDTH+1){1'b0}}, dvd_mag_in};
                     cnt     <= '0;
                     state   <= S_ON;
                  end
               end
            end
            S_DIVZERO: begin
               quotient     <= '0;
               remainder    <= '0;
               result_valid <= 1'b1;
               state        <= S_END;
            end
            S_ON: begin
               work <= work_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  quotient     <= q_fin;
                  remainder    <= r_fin;
                  result_valid <= 1'b1;
                  state        <= S_END;
               end
            end
            default: begin
               result_valid <= 1'b0;
               state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operands against an arithmetic reference model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        start;
   logic        signed_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        stallreq_for_ex;
   logic        result_valid;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_chk  = 0;
   int n_fail = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .flush           (flush),
      .start           (start),
      .signed_div      (signed_div),
      .dividend        (dividend),
      .divisor         (divisor),
      .stallreq_for_ex (stallreq_for_ex),
      .result_valid    (result_valid),
      .quotient        (quotient),
      .remainder       (remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero
   function automatic void model(input logic sd, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = '0; r = '0;
      end else if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one divide at T0 (current cycle), hold start while stalled,
   // optionally scramble operands at T5, check latency and results.
   task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         input bit perturb);
      logic [31:0] eq, er;
      int n, lat;
      bit got;
      model(sd, a, b, eq, er);
      lat        = (b == 32'd0) ? 2 : 33;
      start      = 1'b1;
      signed_div = sd;
      dividend   = a;
      divisor    = b;
      #1;
      check("stall_t0", stallreq_for_ex, 1);
      n = 0; got = 0;
      while (!got && n < 40) begin
         tick();
         n++;
         if (result_valid) got = 1;
         else check("stall_busy", stallreq_for_ex, 1);
         if (perturb && n == 5) begin
            dividend   = ~dividend;
            divisor    = divisor + 32'd3;
            signed_div = ~signed_div;
         end
      end
      check("latency", n, lat);
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("stall_end", stallreq_for_ex, 0);
      start = 1'b0;
      tick();
      check("valid_drop", result_valid, 0);
      check("q_hold", quotient, eq);
      check("r_hold", remainder, er);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      resetn = 1'b0; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
      dividend = '0; divisor = '0;
      #2;
      check("rst_valid", result_valid, 0);
      check("rst_quot", quotient, 0);
      check("rst_rem", remainder, 0);
      check("rst_stall0", stallreq_for_ex, 0);
      start = 1'b1;
      #1;
      check("rst_stall1", stallreq_for_ex, 1);
      start = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      tick();

      // directed cases
      do_div(1'b1, 32'd7, 32'd2, 0);
      do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_div(1'b0, 32'hFFFF_FFFF, 32'd2, 1);
      do_div(1'b1, 32'd12345, 32'd0, 0);
      do_div(1'b0, 32'd0, 32'd0, 0);
      do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
      do_div(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 0);
      do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_div(1'b0, 32'd5, 32'd9, 0);

      // flush at T10: no result, back in IDLE at T11, fresh start at T12
      start = 1'b1; signed_div = 1'b0; dividend = 32'd50000; divisor = 32'd7;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("flush_noval", result_valid, 0);
      end
      flush = 1'b1;
      tick();
      check("flush_t11_val", result_valid, 0);
      flush = 1'b0;
      start = 1'b0;
      tick();
      check("flush_t12_val", result_valid, 0);
      do_div(1'b0, 32'd1000, 32'd3, 0);

      // asynchronous reset at T20 mid-operation
      start = 1'b1; signed_div = 1'b0; dividend = 32'd98765; divisor = 32'd11;
      for (int i = 1; i <= 20; i++) tick();
      #2;
      resetn = 1'b0;
      #1;
      check("arst_valid", result_valid, 0);
      check("arst_quot", quotient, 0);
      check("arst_rem", remainder, 0);
      check("arst_stall", stallreq_for_ex, 1);
      start = 1'b0;
      #1;
      check("arst_stall0", stallreq_for_ex, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      tick();
      do_div(1'b0, 32'd100, 32'd7, 0);

      // random operands
      for (int k = 0; k < 30; k++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 4))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         do_div(rs, ra, rb, bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
